// File: rtl/morse_pkg.sv
// Shared types and timing ratios for the Morse key sequencer.
package morse_pkg;

    localparam int DOT_DASH_UNITS   = 2;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS   = 7;

    // len is 3 bits wide, so no letter can carry more than 7 symbols
    localparam int TOKEN_BITS_MAX = 7;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        SPACE_WAIT
    } state_t;

    typedef struct packed {
        logic                      space;
        logic                      err;
        logic [2:0]                len;
        logic [TOKEN_BITS_MAX-1:0] bits;
    } token_t;

endpackage

// File: rtl/morse_token_reg.sv
// Single-entry valid/ready holding register; a load that finds it full is dropped
// and flagged with a one-cycle overrun pulse.
module morse_token_reg
    import morse_pkg::*;
#(
    parameter type T = token_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  T     din,
    input  logic ready,
    output logic valid,
    output T     dout,
    output logic overrun
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            dout    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (clr) begin
                valid <= 1'b0;
                dout  <= '0;
            end else if (load) begin
                // an accept in the same cycle frees the slot for the new token
                if (!valid || ready) begin
                    valid <= 1'b1;
                    dout  <= din;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/morse_key_sequencer.sv
// Turns a debounced key level into dot/dash letters and word-space tokens
// using press and gap durations measured in Morse units.
module morse_key_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int MAX_SYMS    = 5,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key,
    input  logic                clr,
    output logic                code_valid,
    input  logic                code_ready,
    output logic [MAX_SYMS-1:0] code_bits,
    output logic [2:0]          code_len,
    output logic                code_space,
    output logic                code_err,
    output logic                overrun
);

    typedef struct packed {
        logic                space;
        logic                err;
        logic [2:0]          len;
        logic [MAX_SYMS-1:0] bits;
    } sym_token_t;

    localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(DOT_DASH_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       SYMS_FULL = 3'(MAX_SYMS);

    state_t              state, state_n;
    logic                key_q;
    logic [CNT_W-1:0]    dur_cnt, dur_n, dur_inc;
    logic [2:0]          sym_cnt, sym_n;
    logic [MAX_SYMS-1:0] bits, bits_n;
    logic                err_flag, err_n;
    logic                rise, fall;
    logic                emit;
    sym_token_t          emit_tok, tok_q;

    assign rise    = key & ~key_q;
    assign fall    = ~key & key_q;
    // the word-gap threshold doubles as the saturation ceiling
    assign dur_inc = (dur_cnt >= WORD_TH) ? dur_cnt : dur_cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_q    <= 1'b0;
            dur_cnt  <= '0;
            sym_cnt  <= '0;
            bits     <= '0;
            err_flag <= 1'b0;
        end else begin
            key_q <= key;
            if (clr) begin
                state    <= IDLE;
                dur_cnt  <= '0;
                sym_cnt  <= '0;
                bits     <= '0;
                err_flag <= 1'b0;
            end else begin
                state    <= state_n;
                dur_cnt  <= dur_n;
                sym_cnt  <= sym_n;
                bits     <= bits_n;
                err_flag <= err_n;
            end
        end
    end

    always_comb begin
        state_n  = state;
        dur_n    = dur_cnt;
        sym_n    = sym_cnt;
        bits_n   = bits;
        err_n    = err_flag;
        emit     = 1'b0;
        emit_tok = '0;
        case (state)
            IDLE: begin
                dur_n = '0;
                if (rise) begin
                    state_n = PRESS;
                    dur_n   = CNT_ONE;
                end
            end
            PRESS: begin
                if (fall) begin
                    if (sym_cnt == SYMS_FULL) begin
                        err_n = 1'b1;
                    end else begin
                        bits_n[sym_cnt] = (dur_cnt >= DASH_TH);
                        sym_n           = sym_cnt + 3'd1;
                    end
                    state_n = GAP;
                    dur_n   = CNT_ONE;
                end else begin
                    dur_n = dur_inc;
                end
            end
            GAP: begin
                // the letter is closed before a coincident rise starts the next one
                if (dur_cnt >= LETTER_TH) begin
                    emit          = 1'b1;
                    emit_tok.bits = bits;
                    emit_tok.len  = sym_cnt;
                    emit_tok.err  = err_flag;
                    sym_n         = '0;
                    bits_n        = '0;
                    err_n         = 1'b0;
                    state_n       = rise ? PRESS : SPACE_WAIT;
                    dur_n         = rise ? CNT_ONE : dur_inc;
                end else if (rise) begin
                    state_n = PRESS;
                    dur_n   = CNT_ONE;
                end else begin
                    dur_n = dur_inc;
                end
            end
            SPACE_WAIT: begin
                if (dur_cnt >= WORD_TH) begin
                    emit           = 1'b1;
                    emit_tok.space = 1'b1;
                    state_n        = rise ? PRESS : IDLE;
                    dur_n          = rise ? CNT_ONE : '0;
                end else if (rise) begin
                    state_n = PRESS;
                    dur_n   = CNT_ONE;
                end else begin
                    dur_n = dur_inc;
                end
            end
            default: begin
                state_n = IDLE;
                dur_n   = '0;
            end
        endcase
    end

    morse_token_reg #(
        .T(sym_token_t)
    ) u_token_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .load    (emit),
        .din     (emit_tok),
        .ready   (code_ready),
        .valid   (code_valid),
        .dout    (tok_q),
        .overrun (overrun)
    );

    assign code_bits  = tok_q.bits;
    assign code_len   = tok_q.len;
    assign code_space = tok_q.space;
    assign code_err   = tok_q.err;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with UNIT_CYCLES=4, MAX_SYMS=5.
module tb_morse_key_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       clr;
    logic       code_ready;
    logic       code_valid;
    logic [4:0] code_bits;
    logic [2:0] code_len;
    logic       code_space;
    logic       code_err;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_n    = 0;
    int ovr_n    = 0;
    int base;
    int ovr0;

    logic [4:0] acc_bits  [0:31];
    logic [2:0] acc_len   [0:31];
    logic       acc_space [0:31];
    logic       acc_err   [0:31];

    morse_key_sequencer #(
        .UNIT_CYCLES(4),
        .MAX_SYMS   (5),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .clr        (clr),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_bits  (code_bits),
        .code_len   (code_len),
        .code_space (code_space),
        .code_err   (code_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Records every handshake and overrun pulse; inputs settle at negedge+1.
    always @(negedge clk) begin
        #2;
        if (code_valid && code_ready) begin
            if (acc_n < 32) begin
                acc_bits[acc_n]  = code_bits;
                acc_len[acc_n]   = code_len;
                acc_space[acc_n] = code_space;
                acc_err[acc_n]   = code_err;
            end
            acc_n++;
        end
        if (overrun) ovr_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic k, input int n);
        key = k;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        hold(1'b0, 1);
        clr = 1'b0;
    endtask

    task automatic chk_tok(input string tag, input int idx, input logic [4:0] b,
                           input logic [2:0] l, input logic s, input logic e);
        chk({tag, "_bits"},  32'(acc_bits[idx]),  32'(b));
        chk({tag, "_len"},   32'(acc_len[idx]),   32'(l));
        chk({tag, "_space"}, 32'(acc_space[idx]), 32'(s));
        chk({tag, "_err"},   32'(acc_err[idx]),   32'(e));
    endtask

    initial begin
        rst_n      = 1'b0;
        key        = 1'b0;
        clr        = 1'b0;
        code_ready = 1'b0;
        hold(1'b0, 2);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_bits",  32'(code_bits),  32'd0);
        chk("rst_len",   32'(code_len),   32'd0);
        chk("rst_space", 32'(code_space), 32'd0);
        chk("rst_err",   32'(code_err),   32'd0);
        chk("rst_ovr",   32'(overrun),    32'd0);
        rst_n = 1'b1;
        hold(1'b0, 2);

        // Letter A: dot then dash, held under backpressure
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 9);
        hold(1'b0, 12);
        chk("a_valid_before", 32'(code_valid), 32'd0);
        hold(1'b0, 1);
        chk("a_valid", 32'(code_valid), 32'd1);
        chk("a_bits",  32'(code_bits),  32'b00010);
        chk("a_len",   32'(code_len),   32'd2);
        chk("a_space", 32'(code_space), 32'd0);
        hold(1'b0, 3);
        chk("a_hold_valid", 32'(code_valid), 32'd1);
        chk("a_hold_bits",  32'(code_bits),  32'b00010);
        chk("a_hold_len",   32'(code_len),   32'd2);
        code_ready = 1'b1;
        hold(1'b0, 1);
        chk("a_acc_n", 32'(acc_n), 32'd1);
        chk_tok("a_tok", 0, 5'b00010, 3'd2, 1'b0, 1'b0);
        chk("a_valid_after", 32'(code_valid), 32'd0);
        hold(1'b1, 3);
        hold(1'b0, 1);
        pulse_clr();
        chk("a_no_space_n", 32'(acc_n), 32'd1);
        chk("clr_valid", 32'(code_valid), 32'd0);

        // Letter E followed by a word gap
        base = acc_n;
        hold(1'b1, 3);
        hold(1'b0, 32);
        chk("wg_acc_n", 32'(acc_n), 32'(base + 2));
        chk_tok("wg_e", base, 5'b00000, 3'd1, 1'b0, 1'b0);
        chk_tok("wg_sp", base + 1, 5'b00000, 3'd0, 1'b1, 1'b0);

        // Backpressure: E held, T dropped with one overrun
        base       = acc_n;
        ovr0       = ovr_n;
        code_ready = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 14);
        chk("bp_e_valid", 32'(code_valid), 32'd1);
        hold(1'b1, 9);
        hold(1'b0, 14);
        chk("bp_ovr_n", 32'(ovr_n), 32'(ovr0 + 1));
        chk("bp_valid", 32'(code_valid), 32'd1);
        chk("bp_bits",  32'(code_bits),  32'd0);
        chk("bp_len",   32'(code_len),   32'd1);
        code_ready = 1'b1;
        hold(1'b0, 1);
        pulse_clr();
        chk("bp_acc_n", 32'(acc_n), 32'(base + 1));
        chk_tok("bp_e", base, 5'b00000, 3'd1, 1'b0, 1'b0);
        chk("bp_ovr_final", 32'(ovr_n), 32'(ovr0 + 1));

        // Overflow: six dots in one letter
        base = acc_n;
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        hold(1'b0, 12);
        chk("of_acc_n", 32'(acc_n), 32'(base + 1));
        chk_tok("of_tok", base, 5'b00000, 3'd5, 1'b0, 1'b1);
        pulse_clr();

        // K with boundary durations: dash(8 cycles), dot(7 cycles), gap of 11
        base = acc_n;
        hold(1'b1, 9);
        hold(1'b0, 3);
        hold(1'b1, 7);
        hold(1'b0, 11);
        hold(1'b1, 8);
        hold(1'b0, 14);
        chk("k_acc_n", 32'(acc_n), 32'(base + 1));
        chk_tok("k_tok", base, 5'b00101, 3'd3, 1'b0, 1'b0);
        pulse_clr();

        // Saturation: a very long press is a single dash
        base = acc_n;
        hold(1'b1, 100);
        hold(1'b0, 14);
        chk("sat_acc_n", 32'(acc_n), 32'(base + 1));
        chk_tok("sat_tok", base, 5'b00001, 3'd1, 1'b0, 1'b0);
        pulse_clr();

        // Reset in the middle of a gap loses the partial letter
        base = acc_n;
        ovr0 = ovr_n;
        hold(1'b1, 3);
        hold(1'b0, 4);
        rst_n = 1'b0;
        hold(1'b0, 2);
        chk("rs_valid", 32'(code_valid), 32'd0);
        rst_n = 1'b1;
        hold(1'b0, 40);
        chk("rs_acc_n", 32'(acc_n), 32'(base));
        hold(1'b1, 9);
        hold(1'b0, 14);
        chk("rs_t_acc_n", 32'(acc_n), 32'(base + 1));
        chk_tok("rs_t", base, 5'b00001, 3'd1, 1'b0, 1'b0);
        pulse_clr();

        // clr after two symbols drops the letter
        base = acc_n;
        hold(1'b1, 3);
        hold(1'b0, 4);
        hold(1'b1, 9);
        hold(1'b0, 2);
        pulse_clr();
        hold(1'b0, 40);
        chk("cl_acc_n", 32'(acc_n), 32'(base));
        chk("cl_ovr_n", 32'(ovr_n), 32'(ovr0));
        hold(1'b1, 9);
        hold(1'b0, 14);
        chk("cl_t_acc_n", 32'(acc_n), 32'(base + 1));
        chk_tok("cl_t", base, 5'b00001, 3'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_key_sequencer.md
# morse_key_sequencer

Classifies a debounced Morse key level into dots and dashes by press duration. Groups symbols into letters using inter-symbol gap timing and hands each completed letter, or a word-space token, to the downstream decoder over a valid/ready handshake. Sits between the button debouncer output and the Morse-to-character lookup/display path.

## Interface
- `UNIT_CYCLES`, default 25_000_000: one Morse time unit in clk cycles (0.25 s at 100 MHz).
- `MAX_SYMS`, default 5: maximum symbols per letter.
- `CNT_W`, default 32: width of the duration counter; must hold 7*UNIT_CYCLES.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key`, input, 1: debounced key level, already synchronous to clk; 1 = pressed.
- `clr`, input, 1: synchronous abort; drops the partial letter and any pending token.
- `code_valid`, output, 1: token available.
- `code_ready`, input, 1: downstream accepts the token.
- `code_bits`, output, MAX_SYMS: symbols; bit0 = first symbol, 1 = dash, 0 = dot; unused bits are 0.
- `code_len`, output, 3: number of symbols (0 for a space token).
- `code_space`, output, 1: token is a word space.
- `code_err`, output, 1: letter exceeded MAX_SYMS.
- `overrun`, output, 1: one-cycle pulse when a token is dropped because the output register is still full.

## Operation
- Internal `key_q` register gives edge detection: rise = key & ~key_q; fall = ~key & key_q.
- FSM states:
  - IDLE: no letter in progress and no space owed. Rise → PRESS, dur_cnt=1.
  - PRESS: dur_cnt increments each cycle while key=1, saturating at 7*UNIT_CYCLES. On fall, classify:
    - dur_cnt < 2*UNIT_CYCLES → dot; otherwise dash.
    - Append at index sym_cnt and increment sym_cnt. If sym_cnt is already MAX_SYMS, drop the symbol and set err_flag.
    - → GAP with dur_cnt=1.
  - GAP: dur_cnt increments while key=0, saturating.
    - Rise before 3*UNIT_CYCLES → PRESS (same letter), dur_cnt=1.
    - dur_cnt reaching 3*UNIT_CYCLES → emit letter token {bits, len, err_flag}, clear sym_cnt/bits/err_flag, → SPACE_WAIT.
  - SPACE_WAIT: counter continues.
    - Rise → PRESS (new letter) with no space token.
    - dur_cnt reaching 7*UNIT_CYCLES → emit space token (len=0, space=1), → IDLE.
- Emitting:
  - If the output register is empty, load it and set code_valid.
  - If it is full, drop the token and pulse overrun. FSM progression is unaffected.
- Output register clears when code_valid & code_ready.
- clr: FSM → IDLE (or PRESS-wait if key is still high: remain IDLE until next rise), clear sym_cnt/bits/err_flag, clear code_valid. clr has priority over every other event.
- A press held past 7*UNIT_CYCLES is still a dash; the counter saturates and never wraps.

## Timing
- Reset values: code_valid=0, code_bits=0, code_len=0, code_space=0, code_err=0, overrun=0, key_q=0, FSM=IDLE, dur_cnt=0.
- Edge detection costs one cycle: a press of N high cycles yields dur_cnt=N at classification.
- code_valid rises the cycle after dur_cnt reaches the threshold in GAP or SPACE_WAIT.
- Token fields are stable while code_valid=1 and code_ready=0.
- Accept and load in the same cycle: the register is treated as empty, so the new token loads and code_valid stays 1 with no overrun.
- Rise in the same cycle as the gap threshold: the threshold wins (token emitted), then the rise is processed → PRESS.
- Reset mid-letter: asynchronous, and all state is lost.

## Structure
- `morse_pkg`:
  - FSM state enum {IDLE, PRESS, GAP, SPACE_WAIT}.
  - Token struct {space, err, len[2:0], bits[MAX_SYMS-1:0]}.
  - Constants DOT_DASH_UNITS=2, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7.
- Sub-module `morse_token_reg`: single-entry valid/ready holding register with load, accept, overrun pulse, and clear.

## Test plan
(UNIT_CYCLES=4, MAX_SYMS=5)
- Letter A: key high 3, low 4, high 9, low 12 cycles → code_bits=5'b00010, code_len=2, code_valid=1; no space token.
- Word gap: after letter E (high 3), hold low 30 cycles with ready=1 → E token (bits=0, len=1), then space token (len=0, space=1).
- Backpressure: ready=0, send E then T with a letter gap → E held stable, T dropped, overrun pulses once; ready=1 then delivers E only.
- Overflow: six dots within a letter → code_len=5, code_bits=0, code_err=1.
- Saturation: key held high 100 cycles, then low 12 → single dash, bits=1, len=1.
- Abort and reset: rst_n low mid-GAP or clr after two symbols → no token; next letter T emits bits=1, len=1.
